hazard_detector: RTL

- Producer side of the forwarding interface. Emits the 2-bit `hazard_op` consumed by the EX-stage forwarding logic.
- Tracks source and destination register tags of in-flight instructions through its own shadow ID→EX→MEM pipeline. Raises `hazard_op` when the EX-stage instruction reads a register that the MEM-stage instruction writes.
- Freezes the pipeline while a MEM-stage load/store waits on data memory, and flags memory timeouts.

---
 rtl/hazard_detector_if.sv | 29 ++
 rtl/hazard_detector.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hazard_detector_if.sv
// Forwarding-interface bundle between the pipeline front end and the hazard detector.
// Master drives the ID-stage instruction, flush and dmem_ready; slave returns forwarding and stall controls.
// Pure wiring: no latency, no state.
interface hazard_detector_if #(
  parameter int XLEN = 32
);
  logic            ID_valid;
  logic [6:0]      ID_opcode;
  logic [2:0]      ID_funct3;
  logic [4:0]      ID_rs1;
  logic [4:0]      ID_rs2;
  logic [4:0]      ID_rd;
  logic            flush;
  logic            dmem_ready;
  logic [1:0]      hazard_op;
  logic            pipeline_stall;
  logic            mem_timeout;
  logic [XLEN-1:0] stall_cycles;

  modport master (
    output ID_valid, ID_opcode, ID_funct3, ID_rs1, ID_rs2, ID_rd, flush, dmem_ready,
    input  hazard_op, pipeline_stall, mem_timeout, stall_cycles
  );

  modport slave (
    input  ID_valid, ID_opcode, ID_funct3, ID_rs1, ID_rs2, ID_rd, flush, dmem_ready,
    output hazard_op, pipeline_stall, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_detector.sv
// Shadow ID->EX->MEM tag pipeline producing EX-stage forwarding selects and memory-wait stalls.
// Latency: hazard_op is registered-state only; pipeline_stall is combinational from MEM state and dmem_ready.
// Backpressure: a MEM load/store without dmem_ready freezes both shadow stages until dmem_ready rises.
module hazard_detector #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  hazard_detector_if.slave  io_bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  // ID decode
  logic w_writes_rd, w_uses_rs1, w_uses_rs2, w_is_memop;

  // EX shadow stage
  logic       r_ex_valid, r_ex_uses_rs1, r_ex_uses_rs2, r_ex_writes, r_ex_memop;
  logic [4:0] r_ex_rs1, r_ex_rs2, r_ex_rd;

  // MEM shadow stage
  logic       r_mem_valid, r_mem_writes, r_mem_memop;
  logic [4:0] r_mem_rd;

  state_t            r_state, w_next_state;
  logic              w_stall, w_mem_miss;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_mem_timeout;
  logic [XLEN-1:0]   r_stall_cycles;

  // Classify the ID instruction's register usage from its opcode
  always_comb begin
    w_writes_rd = 1'b0;
    w_uses_rs1  = 1'b1;
    w_uses_rs2  = 1'b0;
    w_is_memop  = 1'b0;
    case (io_bus.ID_opcode)
      OPC_LOAD:   begin w_writes_rd = 1'b1; w_is_memop = 1'b1; end
      OPC_STORE:  begin w_uses_rs2 = 1'b1; w_is_memop = 1'b1; end
      OPC_BRANCH: w_uses_rs2 = 1'b1;
      OPC_OP:     begin w_writes_rd = 1'b1; w_uses_rs2 = 1'b1; end
      OPC_OP_IMM: w_writes_rd = 1'b1;
      OPC_JALR:   w_writes_rd = 1'b1;
      OPC_JAL:    begin w_writes_rd = 1'b1; w_uses_rs1 = 1'b0; end
      OPC_LUI:    begin w_writes_rd = 1'b1; w_uses_rs1 = 1'b0; end
      OPC_AUIPC:  begin w_writes_rd = 1'b1; w_uses_rs1 = 1'b0; end
      OPC_SYSTEM: begin w_writes_rd = 1'b1; w_uses_rs1 = ~io_bus.ID_funct3[2]; end
      default:    ;
    endcase
    // x0 is never a real destination, so it can never be forwarded
    if (io_bus.ID_rd == 5'd0) w_writes_rd = 1'b0;
  end

  // Advance the shadow stages unless frozen; a frozen pipe also ignores flush
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_uses_rs1 <= 1'b0;
      r_ex_uses_rs2 <= 1'b0;
      r_ex_writes   <= 1'b0;
      r_ex_memop    <= 1'b0;
      r_ex_rs1      <= 5'd0;
      r_ex_rs2      <= 5'd0;
      r_ex_rd       <= 5'd0;
      r_mem_valid   <= 1'b0;
      r_mem_writes  <= 1'b0;
      r_mem_memop   <= 1'b0;
      r_mem_rd      <= 5'd0;
    end else if (!w_stall) begin
      r_ex_valid    <= io_bus.ID_valid & ~io_bus.flush;
      r_ex_uses_rs1 <= w_uses_rs1;
      r_ex_uses_rs2 <= w_uses_rs2;
      r_ex_writes   <= w_writes_rd;
      r_ex_memop    <= w_is_memop;
      r_ex_rs1      <= io_bus.ID_rs1;
      r_ex_rs2      <= io_bus.ID_rs2;
      r_ex_rd       <= io_bus.ID_rd;
      r_mem_valid   <= r_ex_valid;
      r_mem_writes  <= r_ex_writes;
      r_mem_memop   <= r_ex_memop;
      r_mem_rd      <= r_ex_rd;
    end
  end

  assign w_mem_miss = r_mem_valid & r_mem_memop & ~io_bus.dmem_ready;

  // Memory-wait state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_next_state;
  end

  // Enter WAIT on the first unready MEM cycle, leave as soon as dmem_ready rises
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN:   if (w_mem_miss) w_next_state = S_WAIT;
      S_WAIT:  if (io_bus.dmem_ready) w_next_state = S_RUN;
      default: w_next_state = S_RUN;
    endcase
  end

  // Freeze in the same cycle the miss is seen, release in the cycle data returns
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_RUN:   w_stall = w_mem_miss;
      S_WAIT:  w_stall = ~io_bus.dmem_ready;
      default: w_stall = 1'b0;
    endcase
  end

  // Count WAIT cycles and latch a sticky timeout once MAX_WAIT of them pass unanswered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if (r_state == S_RUN && w_next_state == S_WAIT) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT && !io_bus.dmem_ready) begin
      if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt >= WAIT_MAX - 1'b1) r_mem_timeout <= 1'b1;
    end
  end

  // Saturating tally of every frozen cycle
  always_ff @(posedge clk) begin
    if (!reset_n)                           r_stall_cycles <= '0;
    else if (w_stall && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 1'b1;
  end

  assign io_bus.hazard_op[0]  = r_ex_valid & r_ex_uses_rs1 & r_mem_valid & r_mem_writes &
                                (r_mem_rd == r_ex_rs1);
  assign io_bus.hazard_op[1]  = r_ex_valid & r_ex_uses_rs2 & r_mem_valid & r_mem_writes &
                                (r_mem_rd == r_ex_rs2);
  assign io_bus.pipeline_stall = w_stall;
  assign io_bus.mem_timeout    = r_mem_timeout;
  assign io_bus.stall_cycles   = r_stall_cycles;

endmodule
